// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit ALU with single-cycle logic/arithmetic ops and
// iterative (one bit per cycle) shifts and shift-add multiply.
// Result and Z/N/C/V flags are registered and only change on a Done pulse.
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BInvert,
    input  logic [2:0]       Operation,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    localparam int SW = $clog2(WIDTH);
    // Counter must be able to hold WIDTH itself for the multiply.
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic               sra_q, sra_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    // Single-cycle datapath, driven straight from the input operands at accept.
    logic [WIDTH-1:0]   mb;
    logic [WIDTH:0]     sum_ext;
    logic               add_v;
    logic [WIDTH-1:0]   diff;
    logic               slt_v;
    logic               slt_lt;
    logic [SW-1:0]      shamt;

    always_comb begin
        mb      = BInvert ? ~B : B;
        sum_ext = {1'b0, A} + {1'b0, mb} + {{WIDTH{1'b0}}, BInvert};
        add_v   = (A[WIDTH-1] == mb[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
        // SLT always subtracts true B, regardless of BInvert.
        diff    = A + ~B + WIDTH'(1);
        slt_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
        slt_lt  = diff[WIDTH-1] ^ slt_v;
        shamt   = B[SW-1:0];
    end

    // One iteration of the shifter and of the shift-add multiplier.
    logic [WIDTH-1:0]   shift_step;
    logic [WIDTH-1:0]   mul_step;

    always_comb begin
        shift_step = sra_q ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}
                           : {acc_q[WIDTH-2:0], 1'b0};
        mul_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state and result-load logic; Result/flags are only loaded when an op finishes.
    logic               load_res;
    logic [WIDTH-1:0]   res_new;
    logic               c_new;
    logic               v_new;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        sra_d    = sra_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        load_res = 1'b0;
        res_new  = '0;
        c_new    = 1'b0;
        v_new    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (Operation)
                        OP_AND: begin load_res = 1'b1; res_new = A & mb; end
                        OP_OR:  begin load_res = 1'b1; res_new = A | mb; end
                        OP_XOR: begin load_res = 1'b1; res_new = A ^ mb; end
                        OP_ADD: begin
                            load_res = 1'b1;
                            res_new  = sum_ext[WIDTH-1:0];
                            c_new    = sum_ext[WIDTH];
                            v_new    = add_v;
                        end
                        OP_SLT: begin
                            load_res = 1'b1;
                            res_new  = {{(WIDTH-1){1'b0}}, slt_lt};
                        end
                        OP_SLL, OP_SRA: begin
                            if (shamt == '0) begin
                                load_res = 1'b1;
                                res_new  = A;
                            end else begin
                                state_d = S_SHIFT;
                                acc_d   = A;
                                count_d = CW'(shamt);
                                sra_d   = (Operation == OP_SRA);
                            end
                        end
                        default: begin
                            if (MUL_EN) begin
                                state_d  = S_MUL;
                                acc_d    = '0;
                                mcand_d  = A;
                                mplier_d = B;
                                count_d  = CW'(WIDTH);
                            end else begin
                                load_res = 1'b1;
                                res_new  = '0;
                            end
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                acc_d   = shift_step;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    load_res = 1'b1;
                    res_new  = shift_step;
                    state_d  = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = mul_step;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    load_res = 1'b1;
                    res_new  = mul_step;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_res) begin
            result_d = res_new;
            zero_d   = (res_new == '0);
            neg_d    = res_new[WIDTH-1];
            carry_d  = c_new;
            ovf_d    = v_new;
            done_d   = 1'b1;
        end
    end

    // State and output registers; reset clears everything and aborts any op.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            sra_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            sra_q    <= sra_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Busy covers exactly the iterative cycles; it is low in the Done cycle.
    always_comb begin
        Busy     = (state_q != S_IDLE);
        Done     = done_q;
        Result   = result_q;
        Zero     = zero_q;
        Negative = neg_q;
        Carry    = carry_q;
        Overflow = ovf_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed tests for alu_seq with hand-computed expectations.
// Outputs are sampled 1 time unit after the rising edge.
module tb_alu_seq;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic        BInvert;
    logic [2:0]  Operation;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic        Zero;
    logic        Negative;
    logic        Carry;
    logic        Overflow;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .BInvert  (BInvert),
        .Operation(Operation),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .Zero     (Zero),
        .Negative (Negative),
        .Carry    (Carry),
        .Overflow (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Flags packed as {Z,N,C,V} for compact comparison.
    function automatic logic [3:0] flags();
        return {Zero, Negative, Carry, Overflow};
    endfunction

    // Drive one op, return latency (cycles from accept to Done, -1 on timeout)
    // and whether Busy was high exactly in the cycles before Done.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic binv, output int lat, output bit busy_ok);
        Operation = op; A = a; B = b; BInvert = binv; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        // Scramble inputs: the DUT must use its captured copies.
        A = 16'hDEAD; B = 16'hBEEF; BInvert = ~binv; Operation = ~op;
        lat = 1; busy_ok = 1'b1;
        while (Done !== 1'b1 && lat < 40) begin
            if (Busy !== 1'b1) busy_ok = 1'b0;
            @(posedge Clock); #1;
            lat++;
        end
        if (Done !== 1'b1) lat = -1;
        else if (Busy !== 1'b0) busy_ok = 1'b0;
        $display("op=%b a=%h b=%h binv=%b -> res=%h zncv=%b lat=%0d", op, a, b, binv, Result, flags(), lat);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; BInvert = 1'b0; Operation = 3'b011;
        repeat (3) @(posedge Clock); #1;
        total++;
        if ({Busy, Done, Result, flags()} !== 22'd0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b res=%h zncv=%b want all 0", Busy, Done, Result, flags());
        end
        Reset = 1'b0; Start = 1'b0;
        $display("reset released res=%h", Result);
    endtask

    task automatic test_add_sub();
        int lat; bit bok;
        run_op(3'b011, 16'h7FFF, 16'h0001, 1'b0, lat, bok);
        total++;
        if (lat !== 1 || bok !== 1'b1) begin bad++; $display("FAIL add_latency got=%0d busy_ok=%b want=1", lat, bok); end
        total++;
        if (Result !== 16'h8000 || flags() !== 4'b0101) begin
            bad++; $display("FAIL add_ovf got res=%h zncv=%b want res=8000 zncv=0101", Result, flags());
        end
        @(posedge Clock); #1;
        total++;
        if (Done !== 1'b0) begin bad++; $display("FAIL done_single_pulse got=%b want=0", Done); end

        run_op(3'b011, 16'h0005, 16'h0005, 1'b1, lat, bok);
        total++;
        if (Result !== 16'h0000 || flags() !== 4'b1010 || lat !== 1) begin
            bad++; $display("FAIL sub_equal got res=%h zncv=%b lat=%0d want res=0000 zncv=1010 lat=1", Result, flags(), lat);
        end
        run_op(3'b011, 16'h0003, 16'h0005, 1'b1, lat, bok);
        total++;
        if (Result !== 16'hFFFE || flags() !== 4'b0100) begin
            bad++; $display("FAIL sub_borrow got res=%h zncv=%b want res=fffe zncv=0100", Result, flags());
        end
        run_op(3'b011, 16'hFFFF, 16'h0001, 1'b0, lat, bok);
        total++;
        if (Result !== 16'h0000 || flags() !== 4'b1010) begin
            bad++; $display("FAIL add_carry got res=%h zncv=%b want res=0000 zncv=1010", Result, flags());
        end
    endtask

    task automatic test_logic();
        int lat; bit bok;
        // Carry is set from the previous ADD; a logic op must clear it.
        run_op(3'b010, 16'hF0F0, 16'h0000, 1'b1, lat, bok);
        total++;
        if (Result !== 16'h0F0F || flags() !== 4'b0000 || lat !== 1) begin
            bad++; $display("FAIL xor_inv got res=%h zncv=%b lat=%0d want res=0f0f zncv=0000 lat=1", Result, flags(), lat);
        end
        run_op(3'b000, 16'hF0F0, 16'hFF00, 1'b0, lat, bok);
        total++;
        if (Result !== 16'hF000 || flags() !== 4'b0100) begin
            bad++; $display("FAIL and got res=%h zncv=%b want res=f000 zncv=0100", Result, flags());
        end
        run_op(3'b000, 16'hF0F0, 16'hFF00, 1'b1, lat, bok);
        total++;
        if (Result !== 16'h00F0) begin bad++; $display("FAIL and_inv got res=%h want 00f0", Result); end
        run_op(3'b001, 16'h00F0, 16'h0F00, 1'b0, lat, bok);
        total++;
        if (Result !== 16'h0FF0) begin bad++; $display("FAIL or got res=%h want 0ff0", Result); end
    endtask

    task automatic test_slt();
        int lat; bit bok;
        run_op(3'b100, 16'h8000, 16'h0001, 1'b0, lat, bok);
        total++;
        if (Result !== 16'h0001 || flags() !== 4'b0000 || lat !== 1) begin
            bad++; $display("FAIL slt_true got res=%h zncv=%b lat=%0d want res=0001 zncv=0000 lat=1", Result, flags(), lat);
        end
        run_op(3'b100, 16'h0002, 16'hFFFD, 1'b1, lat, bok);
        total++;
        if (Result !== 16'h0000 || flags() !== 4'b1000) begin
            bad++; $display("FAIL slt_false got res=%h zncv=%b want res=0000 zncv=1000", Result, flags());
        end
    endtask

    task automatic test_shift();
        int lat; bit bok;
        run_op(3'b110, 16'h8000, 16'h0004, 1'b0, lat, bok);
        total++;
        if (lat !== 5 || bok !== 1'b1) begin bad++; $display("FAIL sra_latency got=%0d busy_ok=%b want=5", lat, bok); end
        total++;
        if (Result !== 16'hF800 || flags() !== 4'b0100) begin
            bad++; $display("FAIL sra_result got res=%h zncv=%b want res=f800 zncv=0100", Result, flags());
        end
        run_op(3'b101, 16'h1234, 16'h0000, 1'b0, lat, bok);
        total++;
        if (lat !== 1 || Result !== 16'h1234) begin
            bad++; $display("FAIL sll_zero got res=%h lat=%0d want res=1234 lat=1", Result, lat);
        end
        // Upper B bits are ignored: shamt = 3.
        run_op(3'b101, 16'h0003, 16'hFFF3, 1'b0, lat, bok);
        total++;
        if (lat !== 4 || bok !== 1'b1 || Result !== 16'h0018) begin
            bad++; $display("FAIL sll_three got res=%h lat=%0d busy_ok=%b want res=0018 lat=4", Result, lat, bok);
        end
    endtask

    task automatic test_back_to_back();
        int c; int lat; bit bok; bit mid_ok;
        logic [15:0] prev;
        prev = Result;
        Operation = 3'b111; A = 16'h0012; B = 16'h0034; BInvert = 1'b0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        c = 1; bok = 1'b1; mid_ok = 1'b1;
        while (Done !== 1'b1 && c < 40) begin
            if (Busy !== 1'b1) bok = 1'b0;
            if (Result !== prev) mid_ok = 1'b0;
            if (c == 3) begin
                Start = 1'b1; Operation = 3'b011; A = 16'h1111; B = 16'h2222;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clock); #1;
            c++;
        end
        Start = 1'b0;
        $display("op=111 a=0012 b=0034 -> res=%h zncv=%b lat=%0d", Result, flags(), c);
        total++;
        if (c !== 17 || bok !== 1'b1 || Busy !== 1'b0) begin
            bad++; $display("FAIL mul_latency got=%0d busy_ok=%b want=17", c, bok);
        end
        total++;
        if (Result !== 16'h03A8 || flags() !== 4'b0000) begin
            bad++; $display("FAIL mul_result got res=%h zncv=%b want res=03a8 zncv=0000", Result, flags());
        end
        total++;
        if (mid_ok !== 1'b1) begin bad++; $display("FAIL mul_hold got changed=1 want result held"); end
        // Start in the Done cycle: accepted at k+17, completes at k+18.
        run_op(3'b011, 16'h0001, 16'h0002, 1'b0, lat, bok);
        total++;
        if (lat !== 1 || Result !== 16'h0003) begin
            bad++; $display("FAIL b2b_add got res=%h lat=%0d want res=0003 lat=1", Result, lat);
        end
    endtask

    task automatic test_reset_abort();
        int lat; bit bok; int c; bit seen;
        run_op(3'b011, 16'h7FFF, 16'h0001, 1'b0, lat, bok);
        Operation = 3'b111; A = 16'h0003; B = 16'h0005; BInvert = 1'b0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        seen = 1'b0;
        for (c = 1; c < 6; c++) begin
            if (Done === 1'b1) seen = 1'b1;
            @(posedge Clock); #1;
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        total++;
        if ({Busy, Done, Result, flags()} !== 22'd0) begin
            bad++; $display("FAIL abort_state got busy=%b done=%b res=%h zncv=%b want all 0", Busy, Done, Result, flags());
        end
        Reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (Done === 1'b1) seen = 1'b1;
            @(posedge Clock); #1;
        end
        $display("aborted mul, done_seen=%b res=%h", seen, Result);
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got seen=%b want=0", seen); end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; A = '0; B = '0; BInvert = 1'b0; Operation = 3'b000;
        test_reset();
        test_add_sub();
        test_logic();
        test_slt();
        test_shift();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
